// File: rtl/alu_exec_stage_if.sv
// Handshake bus for alu_exec_stage: operand/opcode input side and registered result side.
// illegal_op exists only when ALU_OPCODE_CHECK_EN is defined.
interface alu_exec_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic [3:0]  ALUcontrol;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ALUresult;
    logic        Zero;
    logic [15:0] op_count;
`ifdef ALU_OPCODE_CHECK_EN
    logic        illegal_op;

    modport master (
        output in_valid, A, B, ALUcontrol, out_ready,
        input  in_ready, out_valid, ALUresult, Zero, op_count, illegal_op
    );
    modport slave (
        input  in_valid, A, B, ALUcontrol, out_ready,
        output in_ready, out_valid, ALUresult, Zero, op_count, illegal_op
    );
`else
    modport master (
        output in_valid, A, B, ALUcontrol, out_ready,
        input  in_ready, out_valid, ALUresult, Zero, op_count
    );
    modport slave (
        input  in_valid, A, B, ALUcontrol, out_ready,
        output in_ready, out_valid, ALUresult, Zero, op_count
    );
`endif
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage: 2-entry input FIFO feeding a combinational ALU into a held output register.
// Optional feature macro: ALU_OPCODE_CHECK_EN (adds the registered illegal_op flag).
module alu_exec_alu (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  ctrl,
    output logic [63:0] result
);
    always_comb begin
        result = '0;
        case (ctrl)
            4'd0:  result = a & b;
            4'd1:  result = a | b;
            4'd2:  result = a + b;
            4'd6:  result = a - b;
            4'd7:  result = (a < b) ? 64'd1 : 64'd0;
            4'd12: result = ~(a | b);
            default: result = '0;
        endcase
    end
endmodule

module alu_exec_stage (
    input  logic             clk,
    input  logic             reset,
    alu_exec_stage_if.slave  bus
);
    localparam int ENTRY_W = 64 + 64 + 4;

    logic [ENTRY_W-1:0] entry_q [2];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    logic [1:0]         count_reg;
    logic [1:0]         count_next;

    logic               out_valid_reg;
    logic [63:0]        result_reg;
    logic               zero_reg;
    logic [15:0]        op_count_reg;

    logic               in_ready_int;
    logic               push;
    logic               pop;
    logic               out_fire;
    logic [ENTRY_W-1:0] head;
    logic [63:0]        alu_result;

    // in_ready looks only at the registered count, so a full FIFO never takes a bypass
    assign in_ready_int = !reset && (count_reg != 2'd2);
    assign push         = bus.in_valid && in_ready_int;
    assign pop          = (count_reg != 2'd0) && (!out_valid_reg || bus.out_ready);
    assign out_fire     = out_valid_reg && bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == 1'(gi)))
                    entry_reg <= {bus.A, bus.B, bus.ALUcontrol};
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign head = entry_q[rd_ptr_reg];

    alu_exec_alu u_alu (
        .a      (head[ENTRY_W-1 -: 64]),
        .b      (head[67:4]),
        .ctrl   (head[3:0]),
        .result (alu_result)
    );

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b1;
            op_count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop) begin
                rd_ptr_reg    <= ~rd_ptr_reg;
                out_valid_reg <= 1'b1;
                result_reg    <= alu_result;
                zero_reg      <= (alu_result == 64'd0);
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
            if (out_fire)
                op_count_reg <= op_count_reg + 16'd1;
        end
    end

`ifdef ALU_OPCODE_CHECK_EN
    logic illegal_reg;
    logic head_illegal;

    always_comb begin
        head_illegal = 1'b1;
        case (head[3:0])
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: head_illegal = 1'b0;
            default: head_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            illegal_reg <= 1'b0;
        else if (pop)
            illegal_reg <= head_illegal;
    end

    assign bus.illegal_op = illegal_reg;
`endif

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.ALUresult = result_reg;
    assign bus.Zero      = zero_reg;
    assign bus.op_count  = op_count_reg;
endmodule
